// File: rtl/mpp_pkg.sv
// rtl/mpp_pkg.sv - shared constants and fetch-state encoding for the fetch unit
package mpp_pkg;

  localparam int ROM_ADDR_W = 16;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with synchronous load/increment, async reset
module pc_reg
  import mpp_pkg::*;
#(
  parameter logic [ROM_ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ROM_ADDR_W-1:0] load_val,
  input  logic                  inc,
  output logic [ROM_ADDR_W-1:0] pc
);

  logic [ROM_ADDR_W-1:0] pc_q;

  // Load wins over increment; increment wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_q + 16'd1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte fetch FSM: ROM handshake with timeout, opcode/operand latches
module fetch_unit
  import mpp_pkg::*;
#(
  parameter logic [ROM_ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned           TIMEOUT  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic                  operand,
  input  logic                  pc_load,
  input  logic [ROM_ADDR_W-1:0] pc_load_val,
  input  logic [DATA_W-1:0]     rom_data,
  input  logic                  rom_ready,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic                  rom_cs,
  output logic                  rom_rd,
  output logic [DATA_W-1:0]     instruction,
  output logic [DATA_W-1:0]     operand_data,
  output logic                  fetch_done,
  output logic                  fetch_err,
  output logic                  busy,
  output logic [ROM_ADDR_W-1:0] pc
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_e          state_q, state_d;
  logic                  target_q, target_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]     instr_q, instr_d;
  logic [DATA_W-1:0]     opd_q, opd_d;
  logic                  pc_load_en;
  logic                  pc_inc;
  logic [ROM_ADDR_W-1:0] pc_w;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load_en),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      target_q   <= 1'b0;
      wait_cnt_q <= 8'd0;
      instr_q    <= '0;
      opd_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      opd_q      <= opd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    opd_d      = opd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d  = ST_REQ;
          target_d = operand;
        end
      end
      ST_REQ: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 8'd0;
      end
      // wait_cnt_q holds the number of WAIT cycles already completed.
      ST_WAIT: begin
        if (rom_ready) begin
          state_d = ST_DONE;
          if (target_q) opd_d = rom_data;
          else          instr_d = rom_data;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_cs     = 1'b0;
    rom_rd     = 1'b0;
    fetch_done = 1'b0;
    fetch_err  = 1'b0;
    busy       = (state_q != ST_IDLE);
    pc_load_en = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: pc_load_en = pc_load;
      ST_REQ:  rom_cs = 1'b1;
      ST_WAIT: begin
        rom_cs = 1'b1;
        rom_rd = 1'b1;
      end
      ST_DONE: begin
        fetch_done = 1'b1;
        pc_inc     = 1'b1;
      end
      ST_ERR:  fetch_err = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr     = pc_w;
  assign pc           = pc_w;
  assign instruction  = instr_q;
  assign operand_data = opd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a transaction model
module tb_fetch_unit;

  localparam int          TMO = 8;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, operand, pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  rom_data;
  logic        rom_ready;
  logic [15:0] rom_addr, pc;
  logic        rom_cs, rom_rd, fetch_done, fetch_err, busy;
  logic [7:0]  instruction, operand_data;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .operand      (operand),
    .pc_load      (pc_load),
    .pc_load_val  (pc_load_val),
    .rom_data     (rom_data),
    .rom_ready    (rom_ready),
    .rom_addr     (rom_addr),
    .rom_cs       (rom_cs),
    .rom_rd       (rom_rd),
    .instruction  (instruction),
    .operand_data (operand_data),
    .fetch_done   (fetch_done),
    .fetch_err    (fetch_err),
    .busy         (busy),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    bit          err;
    logic [15:0] pc_after;
    logic [7:0]  instr;
    logic [7:0]  opd;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  rom[65536];
  logic [15:0] m_pc;
  logic [7:0]  m_instr, m_opd;

  // Monitor: pops one expectation per completion pulse, checks pc one cycle later.
  exp_t        mon_e;
  bit          pend_pc;
  logic [15:0] pend_pc_val;
  bit          prev_pulse;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_pc    = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (pend_pc) begin
        chk("pc_after_fetch", pc, pend_pc_val);
        pend_pc = 1'b0;
      end
      if (fetch_done || fetch_err) begin
        chk("pulse_exclusive", {31'd0, fetch_done & fetch_err}, 0);
        chk("pulse_not_consecutive", {31'd0, prev_pulse}, 0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b with no fetch outstanding",
                   fetch_done, fetch_err);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind_err", {31'd0, fetch_err}, {31'd0, mon_e.err});
          chk("instruction", {24'd0, instruction}, {24'd0, mon_e.instr});
          chk("operand_data", {24'd0, operand_data}, {24'd0, mon_e.opd});
          pend_pc     = 1'b1;
          pend_pc_val = mon_e.pc_after;
        end
      end
      prev_pulse = fetch_done || fetch_err;
    end
  end

  // delay = WAIT cycles with rom_ready low before it rises; delay >= TMO never answers.
  task automatic do_fetch(input bit op, input bit ld, input logic [15:0] ldv,
                          input int delay, input bit noise);
    logic [15:0] addr;
    int          waits;
    exp_t        e;
    @(negedge clk);
    fetch_req   = 1'b1;
    operand     = op;
    pc_load     = ld;
    pc_load_val = ldv;
    addr = ld ? ldv : m_pc;
    if (delay < TMO) begin
      if (op) m_opd = rom[addr];
      else    m_instr = rom[addr];
      m_pc = addr + 16'd1;
      e.err = 1'b0;
    end else begin
      m_pc  = addr;
      e.err = 1'b1;
    end
    e.pc_after = m_pc;
    e.instr    = m_instr;
    e.opd      = m_opd;
    sb.push_back(e);
    @(negedge clk);
    fetch_req   = 1'b0;
    pc_load     = 1'b0;
    operand     = 1'($urandom);
    pc_load_val = 16'($urandom);
    rom_ready   = 1'($urandom);
    chk("req_rom_addr", {16'd0, rom_addr}, {16'd0, addr});
    chk("req_cs_rd", {30'd0, rom_cs, rom_rd}, 32'b10);
    chk("req_busy", {31'd0, busy}, 1);
    waits = 0;
    @(negedge clk);
    while (rom_rd === 1'b1 && waits < 300) begin
      waits++;
      rom_ready = (waits > delay);
      rom_data  = rom[rom_addr];
      if (noise) begin
        fetch_req   = 1'($urandom);
        pc_load     = 1'($urandom);
        pc_load_val = 16'($urandom);
      end
      @(negedge clk);
    end
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    rom_ready = 1'($urandom);
    rom_data  = 8'($urandom);
    chk("wait_cycles", waits, (delay < TMO) ? delay + 1 : TMO);
    chk("end_pulse", {30'd0, fetch_done, fetch_err}, (delay < TMO) ? 32'b10 : 32'b01);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_cs_rd", {30'd0, rom_cs, rom_rd}, 0);
  endtask

  task automatic do_load(input logic [15:0] val);
    @(negedge clk);
    pc_load     = 1'b1;
    pc_load_val = val;
    m_pc        = val;
    @(negedge clk);
    pc_load = 1'b0;
    chk("pc_load", {16'd0, pc}, {16'd0, val});
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    fetch_req = 1'b1;
    operand   = 1'b0;
    pc_load   = 1'b0;
    @(negedge clk);
    fetch_req = 1'b0;
    rom_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_in_wait", {31'd0, rom_rd}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_rd", {30'd0, rom_cs, rom_rd}, 0);
    chk("rst_pc", {16'd0, pc}, {16'd0, RPC});
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_instr_opd", {16'd0, instruction, operand_data}, 0);
    m_pc    = RPC;
    m_instr = 8'h00;
    m_opd   = 8'h00;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[0]        = 8'hA5;
    rom[16'hFFFF] = 8'h3C;
    m_pc    = RPC;
    m_instr = 8'h00;
    m_opd   = 8'h00;
    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    operand     = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 16'h0000;
    rom_data    = 8'h00;
    rom_ready   = 1'b0;
    #12;
    chk("reset_pc", {16'd0, pc}, {16'd0, RPC});
    chk("reset_instr_opd", {16'd0, instruction, operand_data}, 0);
    chk("reset_outputs", {27'd0, rom_cs, rom_rd, fetch_done, fetch_err, busy}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    do_fetch(1'b0, 1'b0, 16'h0000, 0, 1'b0);
    chk("first_fetch_instr", {24'd0, instruction}, 32'hA5);
    chk("first_fetch_pc", {16'd0, pc}, 32'h0001);

    do_fetch(1'b1, 1'b1, 16'hFFFF, 0, 1'b0);
    chk("wrap_operand", {24'd0, operand_data}, 32'h3C);
    chk("wrap_instr_kept", {24'd0, instruction}, 32'hA5);
    chk("wrap_pc", {16'd0, pc}, 32'h0000);

    do_fetch(1'b0, 1'b0, 16'h0000, 255, 1'b0);
    chk("timeout_pc", {16'd0, pc}, 32'h0000);
    chk("timeout_instr", {24'd0, instruction}, 32'hA5);

    do_fetch(1'b0, 1'b0, 16'h0000, 5, 1'b1);
    chk("late_ready_pc", {16'd0, pc}, 32'h0001);

    reset_mid_wait();
    do_fetch(1'b0, 1'b0, 16'h0000, 0, 1'b0);
    chk("post_reset_pc", {16'd0, pc}, 32'h0001);
    chk("post_reset_instr", {24'd0, instruction}, 32'hA5);

    do_load(16'($urandom));
    for (int n = 0; n < 40; n++) begin
      do_fetch(1'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom),
               $urandom_range(0, 10), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-002 Parameter TIMEOUT, default 8: maximum WAIT cycles without rom_ready before a fetch aborts (range 1..255).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 fetch_req  in  1  request to fetch one byte at PC; sampled in IDLE only.
REQ-006 operand  in  1  qualifies fetch_req: 0 = opcode byte (to instruction), 1 = operand byte (to operand_data).
REQ-007 pc_load  in  1  load PC from pc_load_val; sampled in IDLE only.
REQ-008 pc_load_val  in  16  jump target.
REQ-009 rom_data  in  8  ROM read data.
REQ-010 rom_ready  in  1  ROM data valid; sampled in WAIT.
REQ-011 rom_addr  out  16  ROM address, always equal to the current PC.
REQ-012 rom_cs  out  1  ROM chip select.
REQ-013 rom_rd  out  1  ROM read strobe.
REQ-014 instruction  out  8  last fetched opcode byte; feeds the microprogram controller.
REQ-015 operand_data  out  8  last fetched operand byte.
REQ-016 fetch_done  out  1  one-cycle pulse: byte latched and PC advanced.
REQ-017 fetch_err  out  1  one-cycle pulse: fetch aborted on timeout.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 pc  out  16  current program counter.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE, ERR; all registered outputs change only on clk rising edge.
REQ-021 IDLE: rom_cs=0, rom_rd=0; fetch_req=1 -> REQ, capturing operand into an internal target flag.
REQ-022 REQ (exactly 1 cycle, address setup): rom_cs=1, rom_rd=0; -> WAIT.
REQ-023 WAIT: rom_cs=1, rom_rd=1; rom_ready=1 at an edge -> DONE with rom_data latched into instruction (flag=0) or operand_data (flag=1); the other register is unchanged.
REQ-024 WAIT timeout: an 8-bit counter clears on entering WAIT and increments each WAIT cycle; rom_ready still 0 after TIMEOUT WAIT cycles -> ERR.
REQ-025 DONE (1 cycle): fetch_done=1, rom_cs=0, rom_rd=0, PC <= PC+1; -> IDLE.
REQ-026 ERR (1 cycle): fetch_err=1, rom_cs=0, PC unchanged, instruction/operand_data unchanged; -> IDLE.
REQ-027 Minimum latency: fetch_req sampled at edge N -> fetch_done high during cycle N+3 (rom_ready=1 in first WAIT cycle).
REQ-028 PC increment is modulo 2^16: 16'hFFFF + 1 = 16'h0000, no flag.
REQ-029 pc_load=1 in IDLE: PC <= pc_load_val at that edge.
REQ-030 pc_load and fetch_req together in IDLE: load takes effect and the fetch reads from pc_load_val (REQ-cycle rom_addr = pc_load_val).
REQ-031 fetch_req or pc_load outside IDLE: ignored, no queuing.
REQ-032 rom_ready outside WAIT: ignored.
REQ-033 fetch_done and fetch_err are mutually exclusive and never high two consecutive cycles.

Reset
REQ-034 rst_n=0 asynchronously forces state=IDLE, pc=RESET_PC, instruction=8'h00, operand_data=8'h00, rom_cs=0, rom_rd=0, fetch_done=0, fetch_err=0, busy=0, timeout counter=0.
REQ-035 Reset asserted mid-fetch (REQ/WAIT/DONE) aborts with no fetch_done/fetch_err pulse and no PC increment.
REQ-036 First fetch_req is accepted at the first rising edge after rst_n deasserts.

Structure
REQ-037 Shared package mpp_pkg holds the fetch-state encoding and the ROM_ADDR_W=16 / DATA_W=8 constants.
REQ-038 One sub-module, pc_reg: 16-bit register with synchronous load, increment, and asynchronous reset to RESET_PC; FSM and latches stay in fetch_unit.

Verification
REQ-039 Reset, then fetch_req=1, operand=0, ROM[0000]=8'hA5, rom_ready in first WAIT cycle -> fetch_done in cycle 3, instruction=8'hA5, pc=16'h0001.
REQ-040 pc_load=1, pc_load_val=16'hFFFF, with fetch_req=1, operand=1, ROM[FFFF]=8'h3C -> rom_addr=FFFF, operand_data=8'h3C, instruction unchanged, pc wraps to 16'h0000.
REQ-041 TIMEOUT=8, rom_ready held 0 -> fetch_err after 8 WAIT cycles, pc and instruction unchanged, busy low on the next cycle.
REQ-042 rom_ready delayed 5 cycles, fetch_req and pc_load pulsed during WAIT -> single fetch_done, both requests ignored, pc=old+1.
REQ-043 rst_n low during WAIT -> rom_cs/rom_rd low immediately, pc=RESET_PC, no fetch_done, next fetch_req served normally.
